// File: rtl/exe_alu_pkg.sv
// exe_alu_pkg: op indices, FSM states and op-class helper for exe_alu_mdu
package exe_alu_pkg;
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;
  localparam int OP_MUL  = 12;
  localparam int OP_MULH = 13;
  localparam int OP_MULHU = 14;
  localparam int OP_DIV  = 15;
  localparam int OP_MOD  = 16;
  localparam int OP_DIVU = 17;
  localparam int OP_MODU = 18;
  localparam int OP_W    = 19;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;
  function automatic logic is_mdu(input logic [OP_W-1:0] op);
    return |op[OP_MODU:OP_MUL];
  endfunction
endpackage

// File: rtl/exe_alu_mdu_if.sv
// exe_alu_mdu_if: op/result handshake bundle between ID/EX and the execute unit
interface exe_alu_mdu_if #(parameter int DATA_W = 32, parameter int TAG_W = 5);
  import exe_alu_pkg::*;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;
  modport master (output flush, in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
                  input in_ready, out_valid, out_result, out_tag, busy);
  modport slave (input flush, in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
                 output in_ready, out_valid, out_result, out_tag, busy);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: magnitude shift-add multiply / restoring divide, one bit per step
module mdu_iter #(parameter int DATA_W = 32) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int W = DATA_W;
  logic [W-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic div_q, div_d;
  logic [W:0] sum, shf, dif;
  // lo holds multiplier/dividend; hi collects product high half or remainder
  always_comb begin
    sum = {1'b0, hi_q} + {1'b0, lo_q[0] ? m_q : '0};
    shf = {hi_q, lo_q[W-1]};
    dif = shf - {1'b0, m_q};
    hi_d = hi_q;
    lo_d = lo_q;
    m_d = m_q;
    div_d = div_q;
    if (load) begin
      hi_d = '0;
      lo_d = a;
      m_d = b;
      div_d = is_div;
    end else if (step && div_q) begin
      hi_d = dif[W] ? shf[W-1:0] : dif[W-1:0];
      lo_d = {lo_q[W-2:0], ~dif[W]};
    end else if (step) begin
      hi_d = sum[W:1];
      lo_d = {sum[0], lo_q[W-1:1]};
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      div_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q <= m_d;
      div_q <= div_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: rtl/exe_alu_mdu.sv
// exe_alu_mdu: execute-stage ALU with iterative mul/div behind valid/ready handshakes
module exe_alu_mdu import exe_alu_pkg::*; #(parameter int DATA_W = 32, parameter int TAG_W = 5) (
  input logic clk,
  input logic reset,
  exe_alu_mdu_if.slave io
);
  localparam int W = DATA_W;
  localparam int SH_W = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0] res_q, res_d, a, b, x, y, simple, fix, mhi, mlo;
  logic [2*W-1:0] pn;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [6:0] sel_q, sel_d, sel_in;
  logic [OP_W-1:0] op;
  logic [SH_W-1:0] sh;
  logic neg_q, neg_d, s1, s2, sgn, accept, load, step;
  assign op = io.in_op;
  assign x = io.in_src1;
  assign y = io.in_src2;
  assign sh = x[SH_W-1:0];
  assign io.in_ready = ~reset & ~io.flush & (state_q == IDLE | (state_q == DONE & io.out_ready));
  assign accept = io.in_valid & io.in_ready;
  assign io.out_valid = state_q == DONE;
  assign io.busy = state_q == BUSY | state_q == FIX;
  assign io.out_result = res_q;
  assign io.out_tag = tag_q;
  // lowest set mul/div bit wins on multi-hot ops
  assign sel_in = op[OP_MODU:OP_MUL] & (~op[OP_MODU:OP_MUL] + 7'd1);
  assign sgn = sel_in[0] | sel_in[1] | sel_in[3] | sel_in[4];
  assign s1 = sgn & x[W-1];
  assign s2 = sgn & y[W-1];
  assign a = s1 ? -x : x;
  assign b = s2 ? -y : y;
  always_comb begin
    simple = ({W{op[OP_ADD]}} & (x + y)) | ({W{op[OP_SUB]}} & (x - y))
           | ({W{op[OP_SLT]}} & W'($signed(x) < $signed(y))) | ({W{op[OP_SLTU]}} & W'(x < y))
           | ({W{op[OP_AND]}} & (x & y)) | ({W{op[OP_NOR]}} & ~(x | y))
           | ({W{op[OP_OR]}} & (x | y)) | ({W{op[OP_XOR]}} & (x ^ y))
           | ({W{op[OP_SLL]}} & (y << sh)) | ({W{op[OP_SRL]}} & (y >> sh))
           | ({W{op[OP_SRA]}} & W'($signed(y) >>> sh)) | ({W{op[OP_LUI]}} & {y[W/2-1:0], {(W/2){1'b0}}});
    pn = neg_q ? -{mhi, mlo} : {mhi, mlo};
    fix = sel_q[0] ? pn[W-1:0] : |sel_q[2:1] ? pn[2*W-1:W]
        : (sel_q[3] | sel_q[5]) ? (neg_q ? -mlo : mlo) : (neg_q ? -mhi : mhi);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    res_d = res_q;
    tag_d = tag_q;
    sel_d = sel_q;
    neg_d = neg_q;
    load = 1'b0;
    step = 1'b0;
    if (io.flush) state_d = IDLE;
    else if (accept) begin
      tag_d = io.in_tag;
      if (is_mdu(op)) begin
        sel_d = sel_in;
        neg_d = sel_in[4] ? s1 : s1 ^ s2;
        cnt_d = CNT_W'(DATA_W);
        load = 1'b1;
        state_d = BUSY;
      end else begin
        res_d = simple;
        state_d = DONE;
      end
    end else if (state_q == BUSY) begin
      step = 1'b1;
      cnt_d = cnt_q - CNT_W'(1);
      state_d = cnt_q == CNT_W'(1) ? FIX : BUSY;
    end else if (state_q == FIX) begin
      res_d = fix;
      state_d = DONE;
    end else if (state_q == DONE && io.out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      res_q <= '0;
      tag_q <= '0;
      sel_q <= '0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      tag_q <= tag_d;
      sel_q <= sel_d;
      neg_q <= neg_d;
    end
  end
  mdu_iter #(.DATA_W(DATA_W)) u_iter (
    .clk(clk), .reset(reset), .load(load), .step(step), .is_div(|sel_in[6:3]),
    .a(a), .b(b), .hi(mhi), .lo(mlo)
  );
endmodule

// File: tb/tb_exe_alu_mdu.sv
// tb_exe_alu_mdu: directed checks of simple ops, mul/div, handshake, flush and reset
module tb_exe_alu_mdu;
  import exe_alu_pkg::*;
  logic clk = 0;
  logic reset = 0;
  int total = 0;
  int bad = 0;
  logic seen;
  exe_alu_mdu_if #(.DATA_W(32), .TAG_W(5)) io();
  exe_alu_mdu #(.DATA_W(32), .TAG_W(5)) dut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;
  function automatic logic [18:0] oh(input int i);
    return 19'(1) << i;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [18:0] op, input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] tag);
    io.in_valid = 1;
    io.in_op = op;
    io.in_src1 = s1;
    io.in_src2 = s2;
    io.in_tag = tag;
  endtask
  task automatic simple(input string tag, input logic [18:0] op, input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] exp);
    put(op, s1, s2, 5'd1);
    step();
    chk({tag, "_valid"}, io.out_valid, 1);
    chk(tag, io.out_result, exp);
  endtask
  task automatic run_mdu(input string tag, input logic [18:0] op, input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] exp);
    int n = 0;
    int nb = 0;
    put(op, s1, s2, 5'd7);
    step();
    io.in_valid = 0;
    while (!io.out_valid && n < 40) begin
      nb += int'(io.busy);
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 33);
    chk({tag, "_busy"}, nb, 33);
    chk(tag, io.out_result, exp);
    chk({tag, "_tag"}, io.out_tag, 7);
    step();
  endtask
  initial begin
    io.flush = 0;
    io.in_valid = 0;
    io.in_op = '0;
    io.in_src1 = '0;
    io.in_src2 = '0;
    io.in_tag = '0;
    io.out_ready = 1;
    #1 reset = 1;
    #2;
    chk("rst_ready", io.in_ready, 0);
    chk("rst_valid", io.out_valid, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_res", io.out_result, 0);
    chk("rst_tag", io.out_tag, 0);
    reset = 0;
    #1;
    chk("rel_ready", io.in_ready, 1);
    step();
    simple("add", oh(OP_ADD), 32'h7FFFFFFF, 32'h1, 32'h80000000);
    simple("slt", oh(OP_SLT), 32'h80000000, 32'h1, 32'h1);
    simple("sltu", oh(OP_SLTU), 32'h80000000, 32'h1, 32'h0);
    simple("xor", oh(OP_XOR), 32'hF0, 32'hFF, 32'h0F);
    io.in_valid = 0;
    step();
    chk("b2b_idle", io.out_valid, 0);
    simple("sra", oh(OP_SRA), 32'd36, 32'h80000000, 32'hF8000000);
    simple("srl", oh(OP_SRL), 32'd36, 32'h80000000, 32'h08000000);
    simple("lui", oh(OP_LUI), 32'h0, 32'h1234, 32'h12340000);
    simple("sll", oh(OP_SLL), 32'd4, 32'h1, 32'h10);
    simple("nor", oh(OP_NOR), 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F);
    simple("sub", oh(OP_SUB), 32'd5, 32'd7, 32'hFFFFFFFE);
    simple("multihot", oh(OP_AND) | oh(OP_OR), 32'hF0, 32'h0F, 32'hFF);
    simple("zerohot", 19'h0, 32'h1234, 32'h5678, 32'h0);
    io.in_valid = 0;
    step();
    run_mdu("mul", oh(OP_MUL), 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE);
    run_mdu("mulh", oh(OP_MULH), 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
    run_mdu("mulhu", oh(OP_MULHU), 32'hFFFFFFFF, 32'h2, 32'h00000001);
    run_mdu("mul_big", oh(OP_MUL), 32'd12345, 32'd678, 32'h007FB6F6);
    run_mdu("mdu_multihot", oh(OP_MUL) | oh(OP_MOD), 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE);
    run_mdu("div", oh(OP_DIV), 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD);
    run_mdu("mod", oh(OP_MOD), 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF);
    run_mdu("div_min", oh(OP_DIV), 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_mdu("mod_min", oh(OP_MOD), 32'h80000000, 32'hFFFFFFFF, 32'h0);
    run_mdu("divu0", oh(OP_DIVU), 32'd5, 32'd0, 32'hFFFFFFFF);
    run_mdu("modu0", oh(OP_MODU), 32'd5, 32'd0, 32'd5);
    run_mdu("divu", oh(OP_DIVU), 32'd100, 32'd7, 32'd14);
    run_mdu("modu", oh(OP_MODU), 32'd100, 32'd7, 32'd2);
    io.out_ready = 0;
    put(oh(OP_ADD), 32'd3, 32'd4, 5'd9);
    step();
    put(oh(OP_SUB), 32'd10, 32'd4, 5'd10);
    repeat (10) begin
      chk("hold_res", io.out_result, 7);
      chk("hold_tag", io.out_tag, 9);
      chk("hold_ready", io.in_ready, 0);
      chk("hold_valid", io.out_valid, 1);
      step();
    end
    io.out_ready = 1;
    #1;
    chk("hold_rel_ready", io.in_ready, 1);
    step();
    io.in_valid = 0;
    chk("b2b_res", io.out_result, 6);
    chk("b2b_tag", io.out_tag, 10);
    chk("b2b_valid", io.out_valid, 1);
    step();
    put(oh(OP_DIV), 32'd100, 32'd7, 5'd2);
    step();
    io.in_valid = 0;
    seen = 0;
    repeat (9) begin
      step();
      seen |= io.out_valid;
    end
    io.flush = 1;
    put(oh(OP_ADD), 32'd1, 32'd1, 5'd3);
    #1;
    chk("flush_ready_low", io.in_ready, 0);
    step();
    io.flush = 0;
    io.in_valid = 0;
    #1;
    chk("flush_ready", io.in_ready, 1);
    chk("flush_valid", io.out_valid, 0);
    chk("flush_busy", io.busy, 0);
    repeat (40) begin
      step();
      seen |= io.out_valid;
    end
    chk("flush_never_valid", seen, 0);
    put(oh(OP_MUL), 32'd3, 32'd5, 5'd4);
    step();
    io.in_valid = 0;
    repeat (5) step();
    chk("mid_busy", io.busy, 1);
    #2 reset = 1;
    #1;
    chk("mid_rst_valid", io.out_valid, 0);
    chk("mid_rst_busy", io.busy, 0);
    chk("mid_rst_res", io.out_result, 0);
    chk("mid_rst_tag", io.out_tag, 0);
    chk("mid_rst_ready", io.in_ready, 0);
    reset = 0;
    #1;
    chk("mid_rel_ready", io.in_ready, 1);
    step();
    chk("mid_rel_valid", io.out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exe_alu_mdu.md
# exe_alu_mdu

Parametrised execute-stage arithmetic unit for the scalar pipeline. It extends the single-cycle integer ALU operation set to DATA_W bits and adds iterative multiply and divide/remainder. Operations are accepted and results returned over valid/ready handshakes, with one operation in flight and a synchronous pipeline flush. It sits between the ID/EX pipeline register and the EX/MEM stage.

## Interface
- DATA_W, 32: operand/result width; power of two, ≥8. SH_W = $clog2(DATA_W).
- TAG_W, 5: width of the sideband tag (destination register) carried with each op.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of the in-flight op.
- in_valid  in  1  op presented.
- in_ready  out  1  unit can accept an op.
- in_op  in  19  one-hot op select: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui, 12 mul, 13 mulh, 14 mulhu, 15 div, 16 mod, 17 divu, 18 modu.
- in_src1, in_src2  in  DATA_W  operands. Shifts use in_src1[SH_W-1:0] as the amount and in_src2 as the data.
- in_tag  in  TAG_W  passed through unchanged to out_tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_result  out  DATA_W  registered result.
- out_tag  out  TAG_W  registered tag.
- busy  out  1  high in BUSY or FIX.

## Operation
- States:
  - IDLE: no op held.
  - BUSY: iterating.
  - FIX: sign correction and result select.
  - DONE: result held.
- Accept: an op is accepted when in_valid & in_ready at a rising edge.
  - in_ready = ~reset & ~flush & (IDLE | (DONE & out_ready)).
- Simple ops (bits 0–11): the result is computed combinationally and registered at the accepting edge, then next state is DONE.
  - Semantics match the existing ALU, widened to DATA_W.
  - lui = {src2[DATA_W/2-1:0], DATA_W/2 zeros}.
  - sra fills with src2 sign; srl fills with zero.
  - slt/sltu return 0 or 1 in bit 0.
- Mul/div ops (bits 12–18): at the accepting edge, latch the op, tag, operand magnitudes and result signs, load cnt = DATA_W, and go to BUSY.
  - Multiply: shift-add over |src1|×|src2| into a 2·DATA_W product. mul takes the low half; mulh (signed×signed) and mulhu (unsigned×unsigned) take the high half.
  - Divide: restoring algorithm, one quotient bit per cycle. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: quotient = all ones, remainder = dividend; no special handling.
  - MIN/−1 (signed): quotient = MIN, remainder = 0. This falls out of the magnitude algorithm.
  - BUSY decrements cnt each edge; on the edge where cnt reaches 0, go to FIX.
  - FIX applies negation where required, writes out_result, and goes to DONE.
- DONE: out_valid = 1; out_result and out_tag are held stable until out_ready.
  - Handshake with no new op accepted: go to IDLE.
  - Handshake plus a new accept in the same edge: load the new op directly (back-to-back, no bubble).
- Zero-hot op: treated as simple, result 0.
- Multi-hot op:
  - If any bit 12–18 is set, the lowest-numbered set bit among 12–18 wins.
  - Otherwise the simple results are OR-combined.
- flush: has priority over all other events. Next state is IDLE, so out_valid is 0 next cycle and any result is discarded. in_valid in the flush cycle is ignored.
- Reset mid-op: immediate return to IDLE.

## Timing
- Latency from accepting edge to out_valid: simple ops 1 cycle; mul/div DATA_W+1 cycles (33 for DATA_W=32).
- Throughput: simple ops 1/cycle while out_ready is held high; mul/div 1 per DATA_W+1 cycles.
- Reset values:
  - state IDLE, out_valid 0, out_result 0, out_tag 0, busy 0, cnt 0.
  - in_ready is 0 while reset is high and 1 after release.
- in_ready does not depend on in_valid. out_valid depends only on state (registered).

## Structure
- Package exe_alu_pkg:
  - op index localparams OP_ADD … OP_MODU and OP_W = 19;
  - state enum {IDLE, BUSY, FIX, DONE};
  - helper predicate is_mdu(op).
- Sub-module mdu_iter (DATA_W): holds the multiply/divide datapath registers and steps one iteration per enable; it has no handshake logic.
- The simple-op datapath, FSM and output registers stay in exe_alu_mdu.

## Test plan
- add 0x7FFFFFFF+1 → 0x80000000; slt 0x80000000,1 → 1; sltu same operands → 0. Each appears 1 cycle after accept; 4 ops issued back-to-back with out_ready=1 produce 4 consecutive out_valid cycles.
- sra src2=0x80000000, src1=36 (amount 4) → 0xF8000000; srl → 0x08000000; lui src2=0x1234 → 0x12340000.
- mul −1×2 → 0xFFFFFFFE; mulh → 0xFFFFFFFF; mulhu → 0x00000001. out_valid rises exactly 33 cycles after accept; busy is high for 33 cycles.
- div −7/2 → 0xFFFFFFFD; mod → 0xFFFFFFFF; div 0x80000000/−1 → 0x80000000, mod 0; divu 5/0 → 0xFFFFFFFF, modu 5/0 → 5.
- Hold out_ready=0 for 10 cycles in DONE: result and tag stay stable and in_ready=0. Raising out_ready with in_valid=1 accepts the next op in the same cycle.
- Pulse flush 10 cycles into a div: out_valid never rises for that op and in_ready=1 next cycle. Asserting reset mid-mul forces all outputs to their reset values asynchronously.
